eqed_inject_ctrl: RTL
=====================

Name: eqed_inject_ctrl

Overview:
Sequences one E-QED single-bit-flip experiment on a design module whose flip-flops carry inverting eqed muxes.
- Latches a target FF and an injection cycle, then runs a signature window.
- Drives a one-hot select onto the FF mux selects for exactly one cycle.
- Compacts the DUT observation outputs into a MISR and compares the final signature against an expected value.
- Holds an exclusion table of already-explained (FF, cycle) candidates; a matching request is suppressed.
- Sits in the E-QED wrapper between the testbench/formal harness and the DUT's FF muxes.

Parameters:
NUM_FF, 8, number of injectable FFs (width of eqed_sel)
FF_IDX_W, 4, width of FF index; indices >= NUM_FF mean "no injection"
CYC_W, 10, width of cycle counter and window length
OBS_W, 3, number of DUT observation bits fed to the MISR
MISR_W, 6, MISR width (OBS_W <= MISR_W, MISR_W >= 3)
NUM_EXCL, 4, exclusion table entries

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin experiment (ignored unless IDLE)
ff_sel  in  FF_IDX_W  target FF, sampled on start
inj_cycle  in  CYC_W  injection cycle within window (1-based), sampled on start
win_len  in  CYC_W  window length in cycles, sampled on start; 0 treated as 1
exp_sig  in  MISR_W  expected final signature, sampled on start
obs  in  OBS_W  DUT outputs to compact
excl_we  in  1  write exclusion entry
excl_idx  in  clog2(NUM_EXCL)  entry index
excl_valid  in  1  entry valid bit written
excl_ff  in  FF_IDX_W  excluded FF index
excl_cyc  in  CYC_W  excluded cycle
eqed_sel  out  NUM_FF  one-hot FF flip select to the DUT muxes
busy  out  1  experiment in progress
done  out  1  one-cycle pulse at end of COMPARE
mismatch  out  1  valid with done: signature != exp_sig
excluded  out  1  valid with done: request matched the exclusion table
injected  out  1  sticky: flip delivered this experiment
signature  out  MISR_W  current MISR state
cycle_count  out  CYC_W  current window cycle

Behaviour:
- Reset values:
  - state IDLE.
  - eqed_sel=0, busy=0, done=0, mismatch=0, excluded=0, injected=0.
  - signature=1 (seed, bit0 set), cycle_count=1.
  - All exclusion entries invalid.
- Reset mid-experiment aborts to IDLE with the same values. No done pulse is produced.
- FSM:
  - IDLE: start -> SEED. Latch the inputs and evaluate the exclusion match (any valid entry with ff==ff_sel and cyc==inj_cycle).
  - SEED: one cycle. MISR=1, cycle_count=1, busy=1 -> RUN.
  - RUN: MISR updates every cycle and cycle_count increments. After the update at cycle_count==win_len -> COMPARE.
  - COMPARE: one cycle. done=1, mismatch=(signature!=exp_sig), excluded latched -> IDLE. busy drops the same cycle.
- Injection:
  - eqed_sel is combinational from state.
  - Asserted only in RUN when cycle_count==inj_cycle, ff_sel<NUM_FF, not excluded, and injected==0. The value is 1<<ff_sel.
  - injected is set the next edge.
  - At most one flip per experiment.
  - Out-of-range inj_cycle (0 or >win_len) or out-of-range ff_sel means no flip; the run still completes.
- MISR update, in RUN only:
  - next[0] = s[MISR_W-2]^s[MISR_W-1]^obs[0]
  - next[i] = s[i-1]^obs[i] for 1<=i<OBS_W
  - next[i] = s[i-1] otherwise
- cycle_count wraps naturally at 2^CYC_W. The window end is decided by an equality compare.
- start while busy is ignored.
- The exclusion table is writable in any state. A write in the IDLE->SEED cycle does not affect the latched match result.

Decomposition:
- Package eqed_pkg holds:
  - the FSM state enum (IDLE, SEED, RUN, COMPARE);
  - the MISR seed constant;
  - the exclusion entry struct {valid, ff, cyc}.
- Sub-module eqed_misr (parameters MISR_W and OBS_W; ports en, seed_ld, obs, sig) holds the compaction logic.

Test Plan:
- obs=0, ff_sel=15 (no inject), win_len=5, exp_sig=0x21 -> done after 5 RUN cycles, signature=0x21, mismatch=0, injected=0, eqed_sel never nonzero.
- Same setup with win_len=6, exp_sig=0x21 -> signature=0x03, mismatch=1.
- ff_sel=2, inj_cycle=3, win_len=5 -> eqed_sel=0x04 for exactly the RUN cycle with cycle_count=3 and 0 elsewhere; injected=1 at done.
- Exclusion entry {1, ff=5, cyc=4}, request ff_sel=5, inj_cycle=4 -> eqed_sel stays 0, excluded=1, injected=0. A request with ff_sel=5, inj_cycle=3 flips normally.
- Second start pulse during RUN -> ignored, exactly one done. rst asserted in RUN -> IDLE next cycle, eqed_sel=0, signature=1, no done pulse.
- inj_cycle=0 and inj_cycle=win_len+1 -> no flip, run completes, injected=0.

Source files
------------

// File: rtl/eqed_pkg.sv
// -----------------------------------------------------------------------------
// eqed_pkg
// Shared types and constants for the E-QED single-bit-flip injection controller.
//   eqed_state_e   : experiment sequencer states
//   MISR_SEED      : value the signature register starts every window from
//   excl_entry_t   : one exclusion-table entry {valid, ff, cyc}
// -----------------------------------------------------------------------------
package eqed_pkg;

    // Field widths of an exclusion entry. The controller's FF_IDX_W / CYC_W
    // parameters default to these and must stay equal to them.
    localparam int EQED_FF_IDX_W = 4;
    localparam int EQED_CYC_W    = 10;

    // Signature seed: only bit 0 set, so an all-zero observation stream still
    // walks a non-trivial pattern through the MISR.
    localparam int MISR_SEED = 1;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        RUN,
        COMPARE
    } eqed_state_e;

    typedef struct packed {
        logic                     valid;
        logic [EQED_FF_IDX_W-1:0] ff;
        logic [EQED_CYC_W-1:0]    cyc;
    } excl_entry_t;

endpackage

// File: rtl/eqed_misr.sv
// -----------------------------------------------------------------------------
// eqed_misr
// Multiple-input signature register compacting the DUT observation bits.
// Shift left by one; bit 0 takes the XOR of the two top bits; the low OBS_W
// bits additionally XOR in one observation bit each.
//   clk, rst : clock, synchronous active-high reset (loads the seed)
//   en       : advance the signature by one step
//   seed_ld  : reload the seed (wins over en)
//   obs      : observation bits folded in on each step
//   sig      : current signature
// -----------------------------------------------------------------------------
module eqed_misr
    import eqed_pkg::*;
#(
    parameter int MISR_W = 6,
    parameter int OBS_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              seed_ld,
    input  logic [OBS_W-1:0]  obs,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_nxt;

    // NOTE: combinational logic uses blocking '=' so later statements see the
    // value just computed; clocked state below uses '<=' only.
    always_comb begin
        sig_nxt = {sig[MISR_W-2:0], sig[MISR_W-1] ^ sig[MISR_W-2]};
        for (int i = 0; i < OBS_W; i++) begin
            sig_nxt[i] = sig_nxt[i] ^ obs[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || seed_ld) begin
            sig <= MISR_W'(MISR_SEED);
        end else if (en) begin
            sig <= sig_nxt;
        end
    end

endmodule

// File: rtl/eqed_inject_ctrl.sv
// -----------------------------------------------------------------------------
// eqed_inject_ctrl
// Sequences one E-QED single-bit-flip experiment: latch the request, seed the
// MISR, run a window of win_len cycles while flipping the target FF for exactly
// one cycle, then compare the final signature against the expected value.
// Requests matching a valid exclusion-table entry run without a flip.
//   clk, rst         : clock, synchronous active-high reset
//   start            : begin an experiment (IDLE only)
//   ff_sel, inj_cycle, win_len, exp_sig : request, sampled with start
//   obs              : DUT observation bits compacted into the MISR
//   excl_*           : exclusion-table write port (any state)
//   eqed_sel         : one-hot flip select to the DUT FF muxes
//   busy             : SEED or RUN in progress
//   done             : one-cycle pulse in COMPARE
//   mismatch, excluded : result flags, valid with done
//   injected         : sticky, the flip was delivered in this experiment
//   signature        : current MISR state
//   cycle_count      : current window cycle (1-based)
// -----------------------------------------------------------------------------
module eqed_inject_ctrl
    import eqed_pkg::*;
#(
    parameter int NUM_FF     = 8,
    parameter int FF_IDX_W   = EQED_FF_IDX_W,
    parameter int CYC_W      = EQED_CYC_W,
    parameter int OBS_W      = 3,
    parameter int MISR_W     = 6,
    parameter int NUM_EXCL   = 4,
    parameter int EXCL_IDX_W = (NUM_EXCL > 1) ? $clog2(NUM_EXCL) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FF_IDX_W-1:0]   ff_sel,
    input  logic [CYC_W-1:0]      inj_cycle,
    input  logic [CYC_W-1:0]      win_len,
    input  logic [MISR_W-1:0]     exp_sig,
    input  logic [OBS_W-1:0]      obs,
    input  logic                  excl_we,
    input  logic [EXCL_IDX_W-1:0] excl_idx,
    input  logic                  excl_valid,
    input  logic [FF_IDX_W-1:0]   excl_ff,
    input  logic [CYC_W-1:0]      excl_cyc,
    output logic [NUM_FF-1:0]     eqed_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic                  excluded,
    output logic                  injected,
    output logic [MISR_W-1:0]     signature,
    output logic [CYC_W-1:0]      cycle_count
);

    eqed_state_e state_q, state_d;

    // Request latched on start.
    logic [FF_IDX_W-1:0] ff_q;
    logic [CYC_W-1:0]    inj_q;
    logic [CYC_W-1:0]    win_q;
    logic [MISR_W-1:0]   exp_q;
    logic                excl_hit_q;

    logic                injected_q;
    logic [CYC_W-1:0]    cnt_q;
    logic                inj_fire;
    logic                excl_match;
    logic                ff_in_range;

    excl_entry_t         excl_tbl [NUM_EXCL];

    // ------------------------------------------------------------------ table
    // NOTE: the table is only a few flops, so whole entries are reset rather
    // than just the valid bits; large RAM-style arrays would reset valid only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_EXCL; i++) begin
                excl_tbl[i] <= '0;
            end
        end else if (excl_we && (int'(excl_idx) < NUM_EXCL)) begin
            excl_tbl[excl_idx] <= '{valid: excl_valid, ff: excl_ff, cyc: excl_cyc};
        end
    end

    // Match against the registered table, so a write landing on the start
    // cycle cannot change the result latched for this request.
    always_comb begin
        excl_match = 1'b0;
        for (int i = 0; i < NUM_EXCL; i++) begin
            if (excl_tbl[i].valid && (excl_tbl[i].ff == ff_sel) &&
                (excl_tbl[i].cyc == inj_cycle)) begin
                excl_match = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ff_in_range = int'(ff_q) < NUM_FF;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        mismatch = 1'b0;
        excluded = 1'b0;
        inj_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEED;
                end
            end
            SEED: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                inj_fire = (cnt_q == inj_q) && ff_in_range && !excl_hit_q && !injected_q;
                // Equality compare: the window ends exactly at win_len even
                // though the counter itself free-wraps.
                if (cnt_q == win_q) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                done     = 1'b1;
                mismatch = (signature != exp_q);
                excluded = excl_hit_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eqed_sel = '0;
        if (inj_fire) begin
            for (int i = 0; i < NUM_FF; i++) begin
                eqed_sel[i] = (int'(ff_q) == i);
            end
        end
    end

    // -------------------------------------------------------- datapath state
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q       <= '0;
            inj_q      <= '0;
            win_q      <= CYC_W'(1);
            exp_q      <= '0;
            excl_hit_q <= 1'b0;
            injected_q <= 1'b0;
            cnt_q      <= CYC_W'(1);
        end else begin
            if (state_q == IDLE && start) begin
                ff_q       <= ff_sel;
                inj_q      <= inj_cycle;
                win_q      <= (win_len == '0) ? CYC_W'(1) : win_len;
                exp_q      <= exp_sig;
                excl_hit_q <= excl_match;
                injected_q <= 1'b0;
            end
            if (state_q == SEED) begin
                cnt_q <= CYC_W'(1);
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + CYC_W'(1);
            end
            if (inj_fire) begin
                injected_q <= 1'b1;
            end
        end
    end

    eqed_misr #(
        .MISR_W (MISR_W),
        .OBS_W  (OBS_W)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == RUN),
        .seed_ld (state_q == SEED),
        .obs     (obs),
        .sig     (signature)
    );

    assign injected    = injected_q;
    assign cycle_count = cnt_q;

endmodule
